// File: rtl/gauss_accumulator_if.sv
// Product-in / pixel-out handshake bundle for the Gaussian window accumulator.
// master = upstream multiplier plus downstream consumer; slave = the accumulator.
interface gauss_accumulator_if;
    logic        prod_valid;
    logic [15:0] prod;
    logic        prod_ready;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_out;

    modport master (
        output prod_valid, prod, pix_ready,
        input  prod_ready, pix_valid, pix_out
    );

    modport slave (
        input  prod_valid, prod, pix_ready,
        output prod_ready, pix_valid, pix_out
    );
endinterface

// File: rtl/gauss_accumulator.sv
// Sums TAPS unsigned kernel products per output pixel, then rounds, normalises
// and saturates the total to 8 bits, holding the pixel until downstream takes it.
module gauss_accumulator #(
    parameter int TAPS  = 9,
    parameter int SHIFT = 4,
    parameter int ACC_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    gauss_accumulator_if.slave bus
);

    localparam int               CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [ACC_W:0]   HALF     = (ACC_W + 1)'(1) << (SHIFT - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tap_cnt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       pix_q;
    logic             pix_valid;
    logic             prod_ready;
    logic             accept;
    logic             closing;
    logic [ACC_W:0]   total;
    logic [ACC_W:0]   rounded;
    logic [ACC_W:0]   scaled;
    logic [7:0]       result;

    // A pending pixel is released and a new product taken in the same cycle.
    assign prod_ready = !pix_valid || bus.pix_ready;
    assign accept     = bus.prod_valid && prod_ready && !clr;
    assign closing    = accept && (tap_cnt == LAST_TAP);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (closing) state_nxt = HOLD;
            HOLD:  if (bus.pix_ready && !closing) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        pix_valid = 1'b0;
        if (state == HOLD) pix_valid = 1'b1;
    end

    // One spare bit keeps total plus rounding from wrapping.
    always_comb begin
        total   = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, bus.prod};
        rounded = total + HALF;
        scaled  = rounded >> SHIFT;
        result  = (|scaled[ACC_W:8]) ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt <= '0;
            acc     <= '0;
            pix_q   <= '0;
        end else if (clr) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (accept) begin
            if (closing) begin
                tap_cnt <= '0;
                acc     <= '0;
                pix_q   <= result;
            end else begin
                tap_cnt <= tap_cnt + CNT_W'(1);
                acc     <= total[ACC_W-1:0];
            end
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.pix_valid  = pix_valid;
    assign bus.pix_out    = pix_q;

endmodule

// File: doc/gauss_accumulator.md
GAUSS_ACCUMULATOR -- requirements
Module: gauss_accumulator

Interface
REQ-001 The block SHALL have parameter TAPS, default 9, meaning the number of products per output pixel (one 3x3 window).
REQ-002 The block SHALL have parameter SHIFT, default 4, meaning the normalisation shift (kernel weight sum 16).
REQ-003 The block SHALL have parameter ACC_W, default 20, meaning the accumulator width; the width SHALL be at least 16+ceil(log2(TAPS)).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port clr, input, 1 bit: synchronous abort of the partial window (frame/line restart).
REQ-007 Port prod_valid, input, 1 bit: prod carries a valid product this cycle.
REQ-008 Port prod, input, 16 bits: unsigned 8x8 product of pixel and kernel coefficient, from the multiplier stage.
REQ-009 Port prod_ready, output, 1 bit: the block accepts prod this cycle.
REQ-010 Port pix_valid, output, 1 bit: pix_out holds a finished pixel.
REQ-011 Port pix_ready, input, 1 bit: downstream accepts pix_out.
REQ-012 Port pix_out, output, 8 bits: normalised, rounded, saturated filtered pixel.

Function
REQ-013 A product SHALL be accepted only on a cycle with prod_valid=1 and prod_ready=1; prod SHALL be ignored on all other cycles.
REQ-014 prod_ready SHALL equal (!pix_valid || pix_ready).
- This is a combinational path from pix_ready.
REQ-015 The block SHALL keep a tap counter running 0..TAPS-1 and an ACC_W-bit accumulator.
- On each accepted product, the accumulator SHALL add prod zero-extended to ACC_W bits.
- The counter SHALL increment on each accepted product.
REQ-016 The product accepted at count TAPS-1 SHALL close the window, with the following effects on the next edge:
- The counter SHALL return to 0.
- The accumulator SHALL return to 0.
- pix_valid SHALL be 1.
- pix_out SHALL be loaded with the result defined in REQ-017.
REQ-017 The result SHALL be computed as follows:
- total = accumulator + prod.
- r = (total + 2^(SHIFT-1)) >> SHIFT, computed without overflow at ACC_W+1 bits.
- pix_out = 255 if r > 255, else r[7:0].
REQ-018 Latency SHALL be exactly 1 cycle from acceptance of the closing product to pix_valid=1.
REQ-019 The state machine SHALL have two states:
- ACCUM: pix_valid=0.
- HOLD: pix_valid=1.
REQ-020 State transitions SHALL be as follows:
- ACCUM to HOLD: when the closing product is accepted.
- HOLD to ACCUM: when pix_ready=1 and no closing product is accepted in the same cycle.
- HOLD to HOLD with new data: when pix_ready=1 and a closing product is accepted in the same cycle; this back-to-back case gives full throughput of one pixel per TAPS cycles, with no bubble.
REQ-021 While in HOLD with pix_ready=0, pix_out and pix_valid SHALL remain stable, and no product SHALL be accepted.
REQ-022 The accumulator SHALL keep accumulating the next window while in HOLD with pix_ready=1.
REQ-023 clr=1 SHALL zero the counter and the accumulator on the next edge.
- Any product presented in the same cycle SHALL be discarded.
- A pending pixel in HOLD SHALL NOT be affected.
REQ-024 The block SHALL NOT require gaps between products; TAPS consecutive accepted products SHALL form one window.

Reset
REQ-025 When rst=1, the following SHALL hold on the next edge:
- Counter = 0.
- Accumulator = 0.
- State = ACCUM.
- pix_valid = 0.
- pix_out = 8'd0.
REQ-026 rst SHALL take priority over clr and over all handshakes.
- Reset mid-window SHALL discard partial sums.
- Reset in HOLD SHALL drop the pending pixel.
REQ-027 prod_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-028 Flat window: products 255,510,255,510,1020,510,255,510,255 on consecutive cycles with pix_ready=1 -> pix_valid=1 one cycle after the ninth product, with pix_out=255 (4088>>4).
REQ-029 Centre-only window: products 0,0,0,0,400,0,0,0,0 -> pix_out=25.
- Then products 0,0,0,0,24,0,0,0,0 -> pix_out=2, which checks rounding: (24+8)>>4.
REQ-030 Saturation: nine products of 65535 -> pix_out=255; no accumulator wrap, so the following window of 16×9 -> pix_out=9.
REQ-031 Back-pressure: complete a window, then hold pix_ready=0 for 3 cycles with prod_valid=1 -> the following SHALL hold:
- pix_valid and pix_out stay stable.
- prod_ready=0.
- The counter does not advance.
- When pix_ready returns to 1, products are accepted that same cycle.
REQ-032 Back-to-back windows: 18 consecutive products of 64 with pix_ready=1 -> two single-cycle pix_valid pulses, 9 cycles apart, each with pix_out=36.
REQ-033 Abort and reset cases:
- clr after 5 products, then 9 products of 32 -> exactly one pixel, with pix_out=18.
- rst asserted after 4 products -> all outputs return to 0; the next 9 products of 16 -> pix_out=9.
